// File: rtl/pc_seq_pkg.sv
// Shared definitions for the IF-stage PC sequencer: FSM state encoding,
// default PC geometry and the stall-counter width.
package pc_seq_pkg;

  localparam int          PC_W_DEF     = 6;
  localparam logic [5:0]  RESET_PC_DEF = 6'd0;
  localparam int          STALL_CNT_W  = 8;
  localparam int          BOOT_CNT_W   = 3;

  // State encodings kept as plain constants so external checkers can match them.
  localparam logic [1:0] S_BOOT  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_STALL = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  typedef enum logic [1:0] {
    ST_BOOT  = S_BOOT,
    ST_RUN   = S_RUN,
    ST_STALL = S_STALL,
    ST_HALT  = S_HALT
  } pc_seq_state_e;

endpackage

// File: rtl/pc_sequencer_mux6.sv
// Two-input next-PC select: sequential (pc+1) versus branch target.
module mux6 #(
  parameter int W = 6
) (
  input  logic [W-1:0] in_adder1,
  input  logic [W-1:0] in_adder2,
  input  logic         cntrl_pc_src,
  output logic [W-1:0] pc_next
);

  // Select 1 picks the branch target, 0 the incremented PC.
  always_comb begin
    pc_next = cntrl_pc_src ? in_adder2 : in_adder1;
  end

endmodule

// File: rtl/pc_sequencer.sv
// IF-stage program-counter sequencer. Owns the PC register, the boot
// warm-up counter, the stall counter and the BOOT/RUN/STALL/HALT FSM, and
// drives the pipeline write-enable and flush controls.
//
// Handshake note: there is no valid/ready pair here. Request inputs are
// level-sensitive and sampled every cycle in RUN/STALL with priority
// halt_req > branch_taken > stall_req; branch_target is only meaningful
// while branch_taken is high. All control outputs are combinational.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int              PC_W        = PC_W_DEF,
  parameter logic [PC_W-1:0] RESET_PC    = PC_W'(RESET_PC_DEF),
  parameter int              BOOT_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   stall_req,
  input  logic                   branch_taken,
  input  logic [PC_W-1:0]        branch_target,
  input  logic                   halt_req,
  output logic [PC_W-1:0]        pc,
  output logic                   fetch_valid,
  output logic                   cntrl_pc_src,
  output logic                   pc_write,
  output logic                   if_id_write,
  output logic                   flush_if_id,
  output logic                   flush_id_ex,
  output logic                   halted,
  output logic [STALL_CNT_W-1:0] stall_count,
  output pc_seq_state_e          state_dbg
);

  pc_seq_state_e          state_q, state_d;
  logic [PC_W-1:0]        pc_q, pc_d;
  logic [BOOT_CNT_W-1:0]  boot_cnt_q, boot_cnt_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [PC_W-1:0]        pc_inc;
  logic [PC_W-1:0]        pc_mux;
  logic                   active;

  // Sequential increment wraps naturally modulo 2^PC_W.
  assign pc_inc = pc_q + PC_W'(1);

  mux6 #(.W(PC_W)) u_mux6 (
    .in_adder1    (pc_inc),
    .in_adder2    (branch_target),
    .cntrl_pc_src (cntrl_pc_src),
    .pc_next      (pc_mux)
  );

  // RUN and STALL behave identically; STALL only records that a bubble was issued.
  assign active = (state_q == ST_RUN) || (state_q == ST_STALL);

  // Pipeline controls and next state from current state and requests.
  always_comb begin
    state_d      = state_q;
    cntrl_pc_src = 1'b0;
    pc_write     = 1'b0;
    if_id_write  = 1'b0;
    flush_if_id  = 1'b0;
    flush_id_ex  = 1'b0;
    stall_cnt_d  = stall_cnt_q;
    boot_cnt_d   = boot_cnt_q;
    case (state_q)
      ST_BOOT: begin
        boot_cnt_d = boot_cnt_q - BOOT_CNT_W'(1);
        if (boot_cnt_d == '0) state_d = ST_RUN;
      end
      ST_RUN, ST_STALL: begin
        if (halt_req) begin
          flush_if_id = 1'b1;
          state_d     = ST_HALT;
        end else if (branch_taken) begin
          cntrl_pc_src = 1'b1;
          pc_write     = 1'b1;
          if_id_write  = 1'b1;
          flush_if_id  = 1'b1;
          flush_id_ex  = 1'b1;
          state_d      = ST_RUN;
        end else if (stall_req) begin
          flush_id_ex = 1'b1;
          state_d     = ST_STALL;
          if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
        end else begin
          pc_write    = 1'b1;
          if_id_write = 1'b1;
          state_d     = ST_RUN;
        end
      end
      default: ; // HALT is terminal until reset
    endcase
  end

  // PC register only moves when the FSM grants a write.
  always_comb begin
    pc_d = pc_write ? pc_mux : pc_q;
  end

  // State, PC and counters; reset is asynchronous.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_BOOT;
      pc_q        <= RESET_PC;
      boot_cnt_q  <= BOOT_CNT_W'(BOOT_CYCLES);
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      boot_cnt_q  <= boot_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Status outputs decoded from registered state.
  always_comb begin
    pc          = pc_q;
    fetch_valid = active;
    halted      = (state_q == ST_HALT);
    stall_count = stall_cnt_q;
    state_dbg   = state_q;
  end

endmodule
